// File: rtl/fp_pkg.sv
// Shared single-precision field widths and the unpacked operand record used
// by the align, normalize and rounding stages.
package fp_pkg;

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRAC_W = 23;
    localparam int unsigned SIG_W  = 24;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [SIG_W-1:0]  sig;
    } fp_unpacked_t;

    // Splits a binary32 word; denormals flush to a zero significand.
    // sign_flip lets the caller fold an add/sub opcode into the sign.
    function automatic fp_unpacked_t fp_unpack(input logic [31:0] x, input logic sign_flip);
        fp_unpacked_t u;
        u.sign = x[31] ^ sign_flip;
        u.exp  = x[FRAC_W+EXP_W-1:FRAC_W];
        u.sig  = (u.exp != '0) ? {1'b1, x[FRAC_W-1:0]} : '0;
        return u;
    endfunction

endpackage

// File: rtl/fp_add_align_barrel_shifter_right.sv
// Logarithmic right shifter for significand alignment. Amounts of 24 and
// above are handled by the caller, so only the low five bits arrive here.
module Barrel_Shifter_Right
    import fp_pkg::*;
(
    input  logic [SIG_W-1:0] data_i,
    input  logic [4:0]       amt_i,
    output logic [SIG_W-1:0] data_o
);

    logic [SIG_W-1:0] s16, s8, s4, s2;

    // Five cascaded stages: 16, 8, 4, 2, 1.
    always_comb begin
        s16    = amt_i[4] ? (data_i >> 16) : data_i;
        s8     = amt_i[3] ? (s16 >> 8)     : s16;
        s4     = amt_i[2] ? (s8 >> 4)      : s8;
        s2     = amt_i[1] ? (s4 >> 2)      : s4;
        data_o = amt_i[0] ? (s2 >> 1)      : s2;
    end

endmodule

// File: rtl/fp_add_align.sv
// Pre-normalize stage of the binary32 adder: unpack, order by magnitude,
// align the smaller significand and perform the effective add/subtract.
// Two registered stages with valid/ready on both sides.
module fp_add_align
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        sign_out,
    output logic [7:0]  exponent_out,
    output logic [24:0] mantissa_out,
    output logic        is_zero,
    output logic        is_inf,
    output logic        is_nan
);

    // ---------------- stage 1: unpack, order, flag ----------------
    fp_unpacked_t     ua, ub;
    logic             a_nan, b_nan, a_inf, b_inf, a_big;
    logic             s1_valid_q;
    fp_unpacked_t     s1_big_q, s1_big_d;
    logic [SIG_W-1:0] s1_small_sig_q, s1_small_sig_d;
    logic [EXP_W-1:0] s1_diff_q, s1_diff_d;
    logic             s1_eff_sub_q, s1_eff_sub_d;
    logic             s1_nan_q, s1_nan_d;
    logic             s1_inf_q, s1_inf_d;
    logic             s1_inf_sign_q, s1_inf_sign_d;
    logic             s1_both_zero_q, s1_both_zero_d;
    logic             s1_load, s2_load;

    // Stage-2 registers double as the output registers.
    logic             s2_valid_q;
    logic             sign_q, sign_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic [SIG_W:0]   mant_q, mant_d;
    logic             zero_q, zero_d, inf_q, inf_d, nan_q, nan_d;

    logic [SIG_W-1:0] shifted, aligned;
    logic [SIG_W:0]   sum;

    // Handshake: each stage loads when empty or when drained this cycle.
    always_comb begin
        s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
        in_ready = !s1_valid_q || s2_load;
        s1_load  = in_valid && in_ready;
    end

    // Unpack both operands, pick the larger magnitude and raise special flags.
    always_comb begin
        ua    = fp_unpack(a, 1'b0);
        ub    = fp_unpack(b, op);
        a_nan = (ua.exp == EXP_MAX) && (a[FRAC_W-1:0] != '0);
        b_nan = (ub.exp == EXP_MAX) && (b[FRAC_W-1:0] != '0);
        a_inf = (ua.exp == EXP_MAX) && (a[FRAC_W-1:0] == '0);
        b_inf = (ub.exp == EXP_MAX) && (b[FRAC_W-1:0] == '0);
        // Ties on both fields keep a as the larger operand.
        a_big = (ua.exp > ub.exp) || ((ua.exp == ub.exp) && (ua.sig >= ub.sig));

        s1_eff_sub_d   = ua.sign ^ ub.sign;
        s1_big_d       = a_big ? ua : ub;
        s1_small_sig_d = a_big ? ub.sig : ua.sig;
        s1_diff_d      = a_big ? (ua.exp - ub.exp) : (ub.exp - ua.exp);
        s1_nan_d       = a_nan || b_nan || (a_inf && b_inf && s1_eff_sub_d);
        s1_inf_d       = a_inf || b_inf;
        s1_inf_sign_d  = a_inf ? ua.sign : ub.sign;
        s1_both_zero_d = (ua.exp == '0) && (ub.exp == '0);
    end

    // Stage-1 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q     <= 1'b0;
            s1_big_q       <= '0;
            s1_small_sig_q <= '0;
            s1_diff_q      <= '0;
            s1_eff_sub_q   <= 1'b0;
            s1_nan_q       <= 1'b0;
            s1_inf_q       <= 1'b0;
            s1_inf_sign_q  <= 1'b0;
            s1_both_zero_q <= 1'b0;
        end else begin
            if (in_ready) s1_valid_q <= in_valid;
            if (s1_load) begin
                s1_big_q       <= s1_big_d;
                s1_small_sig_q <= s1_small_sig_d;
                s1_diff_q      <= s1_diff_d;
                s1_eff_sub_q   <= s1_eff_sub_d;
                s1_nan_q       <= s1_nan_d;
                s1_inf_q       <= s1_inf_d;
                s1_inf_sign_q  <= s1_inf_sign_d;
                s1_both_zero_q <= s1_both_zero_d;
            end
        end
    end

    // ---------------- stage 2: align and add ----------------
    Barrel_Shifter_Right u_shr (
        .data_i (s1_small_sig_q),
        .amt_i  (s1_diff_q[4:0]),
        .data_o (shifted)
    );

    // Truncating alignment, effective add/sub, then special-case overrides.
    always_comb begin
        aligned = (s1_diff_q >= 8'd24) ? '0 : shifted;
        sum     = s1_eff_sub_q ? ({1'b0, s1_big_q.sig} - {1'b0, aligned})
                               : ({1'b0, s1_big_q.sig} + {1'b0, aligned});
        sign_d  = s1_big_q.sign;
        exp_d   = s1_big_q.exp;
        mant_d  = sum;
        zero_d  = 1'b0;
        inf_d   = 1'b0;
        nan_d   = 1'b0;
        if (s1_nan_q) begin
            sign_d = 1'b0;
            exp_d  = EXP_MAX;
            mant_d = '0;
            nan_d  = 1'b1;
        end else if (s1_inf_q) begin
            sign_d = s1_inf_sign_q;
            exp_d  = EXP_MAX;
            mant_d = '0;
            inf_d  = 1'b1;
        end else if (s1_both_zero_q || (s1_eff_sub_q && (sum == '0))) begin
            mant_d = '0;
            zero_d = 1'b1;
            if (s1_eff_sub_q) sign_d = 1'b0;
        end
    end

    // Stage-2 / output register; holds while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            sign_q     <= 1'b0;
            exp_q      <= '0;
            mant_q     <= '0;
            zero_q     <= 1'b0;
            inf_q      <= 1'b0;
            nan_q      <= 1'b0;
        end else begin
            if (!s2_valid_q || out_ready) s2_valid_q <= s1_valid_q;
            if (s2_load) begin
                sign_q <= sign_d;
                exp_q  <= exp_d;
                mant_q <= mant_d;
                zero_q <= zero_d;
                inf_q  <= inf_d;
                nan_q  <= nan_d;
            end
        end
    end

    assign out_valid    = s2_valid_q;
    assign sign_out     = sign_q;
    assign exponent_out = exp_q;
    assign mantissa_out = mant_q;
    assign is_zero      = zero_q;
    assign is_inf       = inf_q;
    assign is_nan       = nan_q;

endmodule

// File: tb/tb_fp_add_align.sv
// Scoreboard bench for fp_add_align: expectations are queued on accept and
// compared whenever the DUT presents a result.
module tb_fp_add_align;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] a, b;
    logic        op;
    logic        out_valid, out_ready;
    logic        sign_out;
    logic [7:0]  exponent_out;
    logic [24:0] mantissa_out;
    logic        is_zero, is_inf, is_nan;

    fp_add_align dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .a            (a),
        .b            (b),
        .op           (op),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .sign_out     (sign_out),
        .exponent_out (exponent_out),
        .mantissa_out (mantissa_out),
        .is_zero      (is_zero),
        .is_inf       (is_inf),
        .is_nan       (is_nan)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [36:0] val;
        int unsigned cyc;
    } sb_t;

    sb_t         sb[$];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned cyc     = 0;
    int unsigned sent    = 0;
    int unsigned recv    = 0;
    logic [36:0] cur_exp;
    logic        chk_lat = 1'b0;
    logic        rnd_ready = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Independent reference: {sign, exp, mant, is_zero, is_inf, is_nan}.
    function automatic logic [36:0] model(input logic [31:0] x, input logic [31:0] y, input logic o);
        logic [7:0]  xe, ye, le, d;
        logic [23:0] xs, ys, ls, ss, al;
        logic        xsg, ysg, lsg, sub, xn, yn, xi, yi;
        logic [24:0] m;
        xe  = x[30:23];
        ye  = y[30:23];
        xsg = x[31];
        ysg = y[31] ^ o;
        sub = xsg ^ ysg;
        xs  = (xe == 0) ? 24'd0 : {1'b1, x[22:0]};
        ys  = (ye == 0) ? 24'd0 : {1'b1, y[22:0]};
        xn  = (xe == 8'hFF) && (x[22:0] != 0);
        yn  = (ye == 8'hFF) && (y[22:0] != 0);
        xi  = (xe == 8'hFF) && (x[22:0] == 0);
        yi  = (ye == 8'hFF) && (y[22:0] == 0);
        if (xn || yn || (xi && yi && sub)) return {1'b0, 8'hFF, 25'd0, 3'b001};
        if (xi) return {xsg, 8'hFF, 25'd0, 3'b010};
        if (yi) return {ysg, 8'hFF, 25'd0, 3'b010};
        if (xe > ye || (xe == ye && xs >= ys)) begin
            le = xe; ls = xs; lsg = xsg; d = xe - ye; ss = ys;
        end else begin
            le = ye; ls = ys; lsg = ysg; d = ye - xe; ss = xs;
        end
        al = (d >= 24) ? 24'd0 : (ss >> d);
        m  = sub ? ({1'b0, ls} - {1'b0, al}) : ({1'b0, ls} + {1'b0, al});
        if (m == 0) return {(sub ? 1'b0 : lsg), le, 25'd0, 3'b100};
        return {lsg, le, m, 3'b000};
    endfunction

    // One cycle: sample after the falling edge, score, then advance.
    task automatic step();
        sb_t e;
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
        #1;
        if (out_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_out", {63'd0, out_valid}, 64'd0);
            end else begin
                e = sb[0];
                chk(out_ready ? "result" : "hold", {sign_out, exponent_out, mantissa_out, is_zero, is_inf, is_nan}, e.val);
                if (out_ready) begin
                    void'(sb.pop_front());
                    recv++;
                    if (chk_lat) chk("latency", cyc - e.cyc, 2);
                end
            end
        end
        if (in_valid && in_ready) begin
            sb.push_back('{val: cur_exp, cyc: cyc});
            sent++;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic o, input logic [36:0] ev);
        int unsigned s0;
        s0       = sent;
        in_valid = 1'b1;
        a        = x;
        b        = y;
        op       = o;
        cur_exp  = ev;
        for (int i = 0; i < 50 && sent == s0; i++) step();
        if (sent == s0) chk("accept_timeout", sent, s0 + 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && sb.size() != 0; i++) step();
        chk("drain_empty", sb.size(), 0);
    endtask

    function automatic logic [31:0] rnd_fp(input logic [7:0] near);
        int unsigned r;
        logic [7:0]  e;
        r = $urandom_range(0, 15);
        e = 8'(int'(near) + $urandom_range(0, 30) - 15);
        if (r == 0) e = 8'h00;
        if (r == 1 || r == 2) e = 8'hFF;
        return {1'($urandom_range(0, 1)), e, (r == 1) ? 23'd0 : 23'($urandom)};
    endfunction

    logic [31:0] va[4], vb[4];
    logic        vo[4];
    int unsigned vi, r0;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        op        = 1'b0;
        out_ready = 1'b1;
        cur_exp   = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 0);
        chk("rst_in_ready", {63'd0, in_ready}, 1);
        chk("rst_outputs", {sign_out, exponent_out, mantissa_out, is_zero, is_inf, is_nan}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases, back-to-back with out_ready high.
        chk_lat = 1'b1;
        send(32'h3F800000, 32'h3F800000, 1'b0, {1'b0, 8'h7F, 25'h1000000, 3'b000});
        send(32'h40000000, 32'h40400000, 1'b1, {1'b1, 8'h80, 25'h0400000, 3'b000});
        send(32'h3FC00000, 32'h3FC00000, 1'b1, {1'b0, 8'h7F, 25'h0000000, 3'b100});
        send(32'h3F800000, 32'h30800000, 1'b0, {1'b0, 8'h7F, 25'h0800000, 3'b000});
        send(32'h3F800000, 32'h34000000, 1'b0, {1'b0, 8'h7F, 25'h0800001, 3'b000});
        send(32'h3F800000, 32'h33800000, 1'b0, {1'b0, 8'h7F, 25'h0800000, 3'b000});
        send(32'h7F800000, 32'h7F800000, 1'b1, {1'b0, 8'hFF, 25'h0000000, 3'b001});
        send(32'h7F800000, 32'h3F800000, 1'b0, {1'b0, 8'hFF, 25'h0000000, 3'b010});
        send(32'h3F800000, 32'h7F800000, 1'b1, {1'b1, 8'hFF, 25'h0000000, 3'b010});
        send(32'h80000000, 32'h80000000, 1'b0, {1'b1, 8'h00, 25'h0000000, 3'b100});
        drain();
        chk_lat = 1'b0;

        // Backpressure: four inputs, consumer stalled for three cycles.
        for (int i = 0; i < 4; i++) begin
            va[i] = 32'h3F800000 + 32'(i << 20);
            vb[i] = 32'h40000000 + 32'(i << 19);
            vo[i] = 1'(i);
        end
        r0        = recv;
        vi        = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            a = va[vi]; b = vb[vi]; op = vo[vi]; cur_exp = model(va[vi], vb[vi], vo[vi]);
            step();
            vi = sent - (sent - vi) + ((sb.size() > 0 && sent > 0) ? 0 : 0);
            vi = sb.size();
        end
        #1;
        chk("bp_accepted", sb.size(), 2);
        chk("bp_in_ready", {63'd0, in_ready}, 0);
        chk("bp_out_valid", {63'd0, out_valid}, 1);
        out_ready = 1'b1;
        for (int c = 0; c < 50 && vi < 4; c++) begin
            a = va[vi]; b = vb[vi]; op = vo[vi]; cur_exp = model(va[vi], vb[vi], vo[vi]);
            r0 = r0;
            begin
                int unsigned s0;
                s0 = sent;
                step();
                if (sent != s0) vi++;
            end
        end
        in_valid = 1'b0;
        drain();
        chk("bp_delivered", recv - r0, 4);

        // Throughput: with the consumer always ready, every cycle accepts.
        begin
            int unsigned s0, c0;
            s0 = sent;
            c0 = cyc;
            in_valid = 1'b1;
            for (int i = 0; i < 8; i++) begin
                a = 32'h3F800000 + 32'(i); b = 32'h3F000000; op = 1'b0;
                cur_exp = model(a, b, op);
                step();
            end
            in_valid = 1'b0;
            chk("throughput", sent - s0, cyc - c0);
            drain();
        end

        // Random traffic with random consumer stalls.
        for (int k = 0; k < 40; k++) begin
            logic [31:0] x, y;
            logic        o;
            x = rnd_fp(8'd127);
            y = ($urandom_range(0, 7) == 0) ? x : rnd_fp(x[30:23]);
            o = 1'($urandom_range(0, 1));
            rnd_ready = 1'b1;
            send(x, y, o, model(x, y, o));
        end
        drain();

        // Reset mid-stream: results in flight are dropped.
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 32'h40400000; b = 32'h3F800000; op = 1'b0; cur_exp = model(a, b, op);
            step();
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {63'd0, out_valid}, 0);
        chk("midrst_in_ready", {63'd0, in_ready}, 1);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) step();
        send(32'h3F800000, 32'h3F800000, 1'b0, {1'b0, 8'h7F, 25'h1000000, 3'b000});
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: time %0t limit 200000", $time);
        $fatal(1);
    end

endmodule
